// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Signal meanings: mem_req asks for a transfer of mem_addr/mem_we/mem_be/mem_wdata;
// mem_ack marks the single cycle in which the transfer completes and mem_rdata is valid.
interface lsu_mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit: one req/ack bus transaction per CPU request, with load
// alignment/extension, misalignment detection and bus timeout.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        buserr,
  output logic [1:0]  o_dbg_state,
  lsu_mem_stage_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_misalign;
  logic        r_buserr;
  logic [7:0]  r_cnt;

  logic [1:0]  w_off;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load;
  logic        w_timeout;

  // Request decode: byte enables and lane-replicated store data.
  always_comb begin
    w_off      = addr[1:0];
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = wdata;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_misalign = w_off[0];
        w_be       = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{wdata[15:0]}};
      end
      default: begin
        w_misalign = (w_off != 2'b00);
      end
    endcase
  end

  // Load format uses the latched size/offset, never the live CPU inputs.
  always_comb begin
    w_lane_b = mem.mem_rdata[7:0];
    case (r_off)
      2'd0:    w_lane_b = mem.mem_rdata[7:0];
      2'd1:    w_lane_b = mem.mem_rdata[15:8];
      2'd2:    w_lane_b = mem.mem_rdata[23:16];
      default: w_lane_b = mem.mem_rdata[31:24];
    endcase
    w_lane_h = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_lane_b[7]}}, w_lane_b};
      2'b01:   w_load = {{16{r_sext & w_lane_h[15]}}, w_lane_h};
      default: w_load = mem.mem_rdata;
    endcase
  end

  assign w_timeout = ((r_cnt + 8'd1) == TO_LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = w_misalign ? S_DONE : S_BUS;
      end
      S_BUS: begin
        if (mem.mem_ack || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_sext     <= 1'b0;
      r_off      <= 2'b00;
      r_addr     <= 32'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_misalign <= 1'b0;
      r_buserr   <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_we       <= we;
            r_size     <= size;
            r_sext     <= sext;
            r_off      <= w_off;
            r_addr     <= {addr[31:2], 2'b00};
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_misalign <= w_misalign;
            r_buserr   <= 1'b0;
            r_cnt      <= 8'd0;
          end
        end
        S_BUS: begin
          // An ack in the timeout cycle still completes the transfer cleanly.
          if (mem.mem_ack) begin
            if (!r_we) r_rdata <= w_load;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) r_buserr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign misalign      = done & r_misalign;
  assign buserr        = done & r_buserr;
  assign rdata         = r_rdata;
  assign o_dbg_state   = r_state;
  assign mem.mem_req   = (r_state == S_BUS);
  assign mem.mem_we    = (r_state == S_BUS) & r_we;
  assign mem.mem_be    = r_be;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: drivers issue requests and push expected
// completions; a monitor pops and compares on every done pulse.
module tb_lsu_mem_stage;
  localparam int W = 34;

  logic        clk;
  logic        rst;
  logic        start;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic        buserr;
  logic [1:0]  dbg_state;

  lsu_mem_stage_if mem_if ();

  lsu_mem_stage #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .we          (we),
    .size        (size),
    .sext        (sext),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .busy        (busy),
    .done        (done),
    .misalign    (misalign),
    .buserr      (buserr),
    .o_dbg_state (dbg_state),
    .mem         (mem_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_rdata;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      logic [W-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_done: got misalign=%b buserr=%b rdata=%h expected no completion",
                 misalign, buserr, rdata);
      end else begin
        e = exp_q.pop_front();
        if ({misalign, buserr, rdata} !== e) begin
          n_errors++;
          $display("FAIL completion: got misalign=%b buserr=%b rdata=%h expected misalign=%b buserr=%b rdata=%h",
                   misalign, buserr, rdata, e[33], e[32], e[31:0]);
        end
      end
    end
  end

  // Driver: issue one request, play the memory side, and check bus/timing.
  // ack_cyc = cycle with mem_ack high (0 = never); restart_cyc = cycle with a stray start.
  task automatic do_txn(
    input string       name,
    input logic        t_we,
    input logic [1:0]  t_size,
    input logic        t_sext,
    input logic [31:0] t_addr,
    input logic [31:0] t_wdata,
    input int          ack_cyc,
    input logic [31:0] bus_rdata,
    input int          restart_cyc,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic        exp_mis,
    input logic        exp_err,
    input logic [31:0] new_rdata,
    input int          exp_done_cyc,
    input int          exp_req_cycles
  );
    int done_cyc;
    int req_cycles;
    int busy_cycles;
    @(negedge clk);
    we    = t_we;
    size  = t_size;
    sext  = t_sext;
    addr  = t_addr;
    wdata = t_wdata;
    start = 1'b1;
    exp_rdata = new_rdata;
    exp_q.push_back({exp_mis, exp_err, exp_rdata});
    done_cyc    = -1;
    req_cycles  = 0;
    busy_cycles = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      mem_if.mem_ack   = (c == ack_cyc);
      mem_if.mem_rdata = (c == ack_cyc) ? bus_rdata : 32'h0;
      if (busy === 1'b1) busy_cycles++;
      if (mem_if.mem_req === 1'b1) begin
        if (req_cycles == 0) begin
          chk({name, "_mem_addr"}, mem_if.mem_addr, {t_addr[31:2], 2'b00});
          chk({name, "_mem_be"}, {28'd0, mem_if.mem_be}, {28'd0, exp_be});
          chk({name, "_mem_wdata"}, mem_if.mem_wdata, exp_wdata);
          chk({name, "_mem_we"}, {31'd0, mem_if.mem_we}, {31'd0, t_we});
        end
        req_cycles++;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    mem_if.mem_ack = 1'b0;
    start = 1'b0;
    chk({name, "_done_cycle"}, done_cyc, exp_done_cyc);
    chk({name, "_req_cycles"}, req_cycles, exp_req_cycles);
    chk({name, "_busy_cycles"}, busy_cycles, exp_done_cyc);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    we = 1'b0;
    size = 2'b00;
    sext = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 32'h0;
    exp_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_flags", {26'd0, busy, done, misalign, buserr, mem_if.mem_req, mem_if.mem_we}, 32'h0);
    chk("reset_be", {28'd0, mem_if.mem_be}, 32'h0);
    chk("reset_mem_addr", mem_if.mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_if.mem_wdata, 32'h0);

    // name, we, size, sext, addr, wdata, ack_cyc, bus_rdata, restart, be, mem_wdata, mis, err, rdata, done, reqs
    do_txn("word_store", 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 1, 32'h0, 0,
           4'b1111, 32'hDEADBEEF, 0, 0, 32'h0, 2, 1);
    do_txn("byte_load_sx", 0, 2'b00, 1, 32'h203, 32'h0, 1, 32'h80FF7F01, 0,
           4'b1000, 32'h0, 0, 0, 32'hFFFFFF80, 2, 1);
    do_txn("byte_load_zx", 0, 2'b00, 0, 32'h203, 32'h0, 1, 32'h80FF7F01, 0,
           4'b1000, 32'h0, 0, 0, 32'h00000080, 2, 1);
    do_txn("half_store", 1, 2'b01, 0, 32'h12, 32'h0000ABCD, 1, 32'h0, 0,
           4'b1100, 32'hABCDABCD, 0, 0, 32'h00000080, 2, 1);
    do_txn("half_load_sx", 0, 2'b01, 1, 32'h12, 32'h0, 1, 32'h80017FFF, 0,
           4'b1100, 32'h0, 0, 0, 32'hFFFF8001, 2, 1);
    do_txn("mis_word", 0, 2'b10, 0, 32'h102, 32'h0, 0, 32'h0, 0,
           4'b1111, 32'h0, 1, 0, 32'hFFFF8001, 1, 0);
    do_txn("mis_half", 0, 2'b01, 1, 32'h101, 32'h0, 0, 32'h0, 0,
           4'b0011, 32'h0, 1, 0, 32'hFFFF8001, 1, 0);
    do_txn("timeout", 0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h0, 2,
           4'b1111, 32'h0, 0, 1, 32'hFFFF8001, 5, 4);
    do_txn("wait3_load", 0, 2'b10, 0, 32'h300, 32'h0, 4, 32'h12345678, 0,
           4'b1111, 32'h0, 0, 0, 32'h12345678, 5, 4);
    do_txn("byte_load_off1", 0, 2'b00, 0, 32'h301, 32'h0, 1, 32'h12345678, 0,
           4'b0010, 32'h0, 0, 0, 32'h00000056, 2, 1);
    do_txn("half_load_zx", 0, 2'b01, 0, 32'h300, 32'h0, 2, 32'h80017FFF, 0,
           4'b0011, 32'h0, 0, 0, 32'h00007FFF, 3, 2);
    do_txn("size11_store", 1, 2'b11, 0, 32'h204, 32'h01020304, 1, 32'h0, 0,
           4'b1111, 32'h01020304, 0, 0, 32'h00007FFF, 2, 1);
    do_txn("ack_at_timeout", 0, 2'b10, 0, 32'h500, 32'h0, 4, 32'hA5A5A5A5, 0,
           4'b1111, 32'h0, 0, 0, 32'hA5A5A5A5, 5, 4);

    // Reset in the middle of a bus cycle, with a late ack that must be ignored.
    @(negedge clk);
    we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid_req_before", {31'd0, mem_if.mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'h0;
    chk("rst_mid_req_after", {31'd0, mem_if.mem_req}, 32'd0);
    chk("rst_mid_busy_after", {31'd0, busy}, 32'd0);
    @(negedge clk);
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_rdata", rdata, 32'h0);

    do_txn("post_reset_store", 1, 2'b00, 0, 32'h602, 32'h000000C3, 2, 32'h0, 0,
           4'b0100, 32'hC3C3C3C3, 0, 0, 32'h0, 3, 2);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
